// File: rtl/pu_tag_result_buf.sv
`default_nettype none
// ============================================================================
// Module      : pu_tag_result_buf
// Description : Per-PU tag-lookup result buffer. Captures up to MAX_RESULTS
//               RCI result words and the completion status of each PU's
//               lookup, and serves PU reads of the tag-lookup response
//               window. PU writes to the tag-lookup request address are
//               snooped so each new lookup starts from a clean entry.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               tag_lookup_valid/result/result_num/result_pid
//                                        - one result word per cycle
//               tag_lookup_status_valid/status/status_pid
//                                        - lookup completion
//               io_req[NUM_OF_PU]        - per-PU access strobe
//               io_cmd[NUM_OF_PU]        - per-PU command {wr, addr, wdata}
//               io_ack[NUM_OF_PU]        - one-cycle acknowledge
//               io_ack_data[NUM_OF_PU]   - read data, zero unless io_ack
// Revision    : 1.0 - initial release
// ============================================================================
module pu_tag_result_buf #(
    parameter int NUM_OF_PU   = 8,
    parameter int WIDTH_NBITS = 32,
    parameter int MAX_RESULTS = 8,
    parameter int RCI_NBITS   = 16,
    parameter int PU_ID_NBITS = 3,
    parameter int ADDR_NBITS  = 12,
    parameter logic [ADDR_NBITS-5:0] TAG_LOOKUP_REQ  = 8'h10,
    parameter logic [ADDR_NBITS-5:0] TAG_LOOKUP_RESP = 8'h11,
    localparam int c_CMD_NBITS = 1 + ADDR_NBITS + WIDTH_NBITS
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    tag_lookup_valid,
    input  logic [RCI_NBITS-1:0]                    tag_lookup_result,
    input  logic [2:0]                              tag_lookup_result_num,
    input  logic [PU_ID_NBITS-1:0]                  tag_lookup_result_pid,
    input  logic                                    tag_lookup_status_valid,
    input  logic [3:0]                              tag_lookup_status,
    input  logic [PU_ID_NBITS-1:0]                  tag_lookup_status_pid,
    input  logic [NUM_OF_PU-1:0]                    io_req,
    input  logic [NUM_OF_PU-1:0][c_CMD_NBITS-1:0]   io_cmd,
    output logic [NUM_OF_PU-1:0]                    io_ack,
    output logic [NUM_OF_PU-1:0][WIDTH_NBITS-1:0]   io_ack_data
);

    localparam int c_SEL_NBITS = ADDR_NBITS - 4;

    genvar p;
    generate
        for (p = 0; p < NUM_OF_PU; p++) begin : g_pu
            // Command decode
            logic                   w_wr;
            logic [ADDR_NBITS-1:0]  w_addr;
            logic [c_SEL_NBITS-1:0] w_sel;
            logic [3:0]             w_off;
            logic [2:0]             w_idx;
            logic                   w_unused_wdata;
            logic                   w_start;
            logic                   w_resp_acc;
            logic                   w_status_rd;
            logic                   w_res_hit;
            logic                   w_st_hit;
            logic [3:0]             w_num_p1;
            logic [31:0]            w_status_word;
            logic [WIDTH_NBITS-1:0] w_rd_data;

            // Entry state
            logic [RCI_NBITS-1:0]   r_res [MAX_RESULTS];
            logic [3:0]             r_cnt;
            logic [3:0]             r_status;
            logic                   r_done;
            logic                   r_busy;
            logic                   r_ack;
            logic [WIDTH_NBITS-1:0] r_ack_data;

            assign w_wr           = io_cmd[p][c_CMD_NBITS-1];
            assign w_addr         = io_cmd[p][c_CMD_NBITS-2 -: ADDR_NBITS];
            assign w_sel          = w_addr[ADDR_NBITS-1:4];
            assign w_off          = w_addr[3:0];
            assign w_idx          = 3'(w_off - 4'd1);
            // Write data is never stored by this block
            assign w_unused_wdata = ^io_cmd[p][WIDTH_NBITS-1:0];

            assign w_start     = io_req[p] & w_wr & (w_sel == TAG_LOOKUP_REQ);
            assign w_resp_acc  = io_req[p] & (w_sel == TAG_LOOKUP_RESP);
            assign w_status_rd = w_resp_acc & ~w_wr & (w_off == 4'd0);
            assign w_res_hit   = tag_lookup_valid &
                                 (tag_lookup_result_pid == PU_ID_NBITS'(p));
            assign w_st_hit    = tag_lookup_status_valid &
                                 (tag_lookup_status_pid == PU_ID_NBITS'(p));
            assign w_num_p1    = {1'b0, tag_lookup_result_num} + 4'd1;

            // Read mux works on pre-update state, so a same-cycle capture
            // is not visible to the read issued in that cycle.
            always_comb begin
                w_status_word        = 32'h0;
                w_status_word[31]    = r_done;
                w_status_word[30]    = r_busy;
                w_status_word[11:8]  = r_cnt;
                w_status_word[3:0]   = r_status;
                w_rd_data            = '0;
                if (!w_wr) begin
                    if (w_off == 4'd0) begin
                        w_rd_data[31:0] = w_status_word;
                    end else if (w_off <= 4'd8) begin
                        if ({1'b0, w_idx} < r_cnt) begin
                            w_rd_data[RCI_NBITS-1:0] = r_res[w_idx];
                        end
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt      <= 4'd0;
                    r_status   <= 4'd0;
                    r_done     <= 1'b0;
                    r_busy     <= 1'b0;
                    r_ack      <= 1'b0;
                    r_ack_data <= '0;
                end else begin
                    r_ack      <= w_resp_acc;
                    r_ack_data <= w_resp_acc ? w_rd_data : '0;
                    if (w_start) begin
                        // A new lookup discards any same-cycle capture
                        r_cnt    <= 4'd0;
                        r_status <= 4'd0;
                        r_done   <= 1'b0;
                        r_busy   <= 1'b1;
                    end else begin
                        if (w_res_hit && (w_num_p1 > r_cnt)) begin
                            r_cnt <= w_num_p1;
                        end
                        if (w_st_hit) begin
                            // Set of done takes priority over read-clear
                            r_status <= tag_lookup_status;
                            r_done   <= 1'b1;
                            r_busy   <= 1'b0;
                        end else if (w_status_rd) begin
                            r_done <= 1'b0;
                        end
                    end
                end
            end

            // Result words need no reset: slots at or above cnt read as 0
            always_ff @(posedge clk) begin
                if (w_res_hit && !w_start) begin
                    r_res[tag_lookup_result_num] <= tag_lookup_result;
                end
            end

            assign io_ack[p]      = r_ack;
            assign io_ack_data[p] = r_ack_data;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pu_tag_result_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_pu_tag_result_buf
// Description : Directed self-checking bench for pu_tag_result_buf.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pu_tag_result_buf;

    localparam int NPU  = 8;
    localparam int W    = 32;
    localparam int RCI  = 16;
    localparam int PIDW = 3;
    localparam int AW   = 12;
    localparam int CMDW = 1 + AW + W;
    localparam logic [7:0] REQ  = 8'h10;
    localparam logic [7:0] RESP = 8'h11;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      tag_lookup_valid;
    logic [RCI-1:0]            tag_lookup_result;
    logic [2:0]                tag_lookup_result_num;
    logic [PIDW-1:0]           tag_lookup_result_pid;
    logic                      tag_lookup_status_valid;
    logic [3:0]                tag_lookup_status;
    logic [PIDW-1:0]           tag_lookup_status_pid;
    logic [NPU-1:0]            io_req;
    logic [NPU-1:0][CMDW-1:0]  io_cmd;
    logic [NPU-1:0]            io_ack;
    logic [NPU-1:0][W-1:0]     io_ack_data;

    int checks = 0;
    int errors = 0;

    pu_tag_result_buf #(
        .NUM_OF_PU       (NPU),
        .WIDTH_NBITS     (W),
        .MAX_RESULTS     (8),
        .RCI_NBITS       (RCI),
        .PU_ID_NBITS     (PIDW),
        .ADDR_NBITS      (AW),
        .TAG_LOOKUP_REQ  (REQ),
        .TAG_LOOKUP_RESP (RESP)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .tag_lookup_valid        (tag_lookup_valid),
        .tag_lookup_result       (tag_lookup_result),
        .tag_lookup_result_num   (tag_lookup_result_num),
        .tag_lookup_result_pid   (tag_lookup_result_pid),
        .tag_lookup_status_valid (tag_lookup_status_valid),
        .tag_lookup_status       (tag_lookup_status),
        .tag_lookup_status_pid   (tag_lookup_status_pid),
        .io_req                  (io_req),
        .io_cmd                  (io_cmd),
        .io_ack                  (io_ack),
        .io_ack_data             (io_ack_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        tag_lookup_valid        = 1'b0;
        tag_lookup_result       = '0;
        tag_lookup_result_num   = '0;
        tag_lookup_result_pid   = '0;
        tag_lookup_status_valid = 1'b0;
        tag_lookup_status       = '0;
        tag_lookup_status_pid   = '0;
        io_req                  = '0;
        io_cmd                  = '0;
    endtask

    // Inputs are applied at a negedge; tick moves past one posedge and
    // lands on the next negedge where outputs are sampled.
    task automatic tick();
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic set_access(input int pu, input logic wr, input logic [7:0] sel,
                              input logic [3:0] off, input logic [W-1:0] wd);
        io_req[pu] = 1'b1;
        io_cmd[pu] = {wr, sel, off, wd};
    endtask

    task automatic set_start(input int pu);
        set_access(pu, 1'b1, REQ, 4'd0, 32'h1234);
    endtask

    task automatic set_result(input int pid, input int num, input logic [RCI-1:0] val);
        tag_lookup_valid      = 1'b1;
        tag_lookup_result     = val;
        tag_lookup_result_num = 3'(num);
        tag_lookup_result_pid = PIDW'(pid);
    endtask

    task automatic set_status(input int pid, input logic [3:0] code);
        tag_lookup_status_valid = 1'b1;
        tag_lookup_status       = code;
        tag_lookup_status_pid   = PIDW'(pid);
    endtask

    task automatic rd(input int pu, input logic [3:0] off, input logic [W-1:0] exp,
                      input string tag);
        set_access(pu, 1'b0, RESP, off, '0);
        tick();
        check({tag, "_ack"}, 64'(io_ack[pu]), 64'd1);
        check(tag, 64'(io_ack_data[pu]), 64'(exp));
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_ack", 64'(io_ack), 64'd0);
        check("reset_data", 64'(^{1'b0, io_ack_data} | (|io_ack_data)), 64'd0);
        rst = 1'b0;

        // Single lookup on PU3
        set_start(3);
        tick();
        check("start_no_ack", 64'(io_ack), 64'd0);
        set_result(3, 0, 16'h0A1); tick();
        set_result(3, 1, 16'h0B2); tick();
        set_status(3, 4'h1);       tick();
        rd(3, 4'd0, 32'h8000_0201, "pu3_status");
        rd(3, 4'd1, 32'h0000_00A1, "pu3_res0");
        rd(3, 4'd2, 32'h0000_00B2, "pu3_res1");
        rd(3, 4'd3, 32'h0000_0000, "pu3_res2_empty");
        rd(3, 4'd0, 32'h0000_0201, "pu3_status_reread");

        // Busy poll on PU5
        set_start(5); tick();
        rd(5, 4'd0, 32'h4000_0000, "pu5_busy");

        // Collisions on PU0
        set_start(0); tick();
        set_result(0, 0, 16'h055); tick();
        set_status(0, 4'h3);
        set_access(0, 1'b0, RESP, 4'd0, '0);
        tick();
        check("pu0_rd_vs_status_ack", 64'(io_ack[0]), 64'd1);
        check("pu0_rd_vs_status", 64'(io_ack_data[0]), 64'h4000_0100);
        rd(0, 4'd0, 32'h8000_0103, "pu0_status_after");
        set_start(0);
        set_result(0, 2, 16'h077);
        tick();
        rd(0, 4'd0, 32'h4000_0000, "pu0_start_vs_result");

        // All PUs read offset 0 together
        for (int i = 0; i < NPU; i++) set_access(i, 1'b0, RESP, 4'd0, '0);
        tick();
        check("parallel_ack", 64'(io_ack), 64'hFF);
        check("parallel_pu3", 64'(io_ack_data[3]), 64'h0000_0201);
        check("parallel_pu5", 64'(io_ack_data[5]), 64'h4000_0000);

        // Out-of-order results on PU1
        set_start(1); tick();
        set_result(1, 7, 16'h0777); tick();
        set_result(1, 0, 16'h0100); tick();
        rd(1, 4'd0, 32'h4000_0800, "pu1_cnt8");
        rd(1, 4'd8, 32'h0000_0777, "pu1_res7");
        rd(1, 4'd1, 32'h0000_0100, "pu1_res0");
        rd(1, 4'd9, 32'h0000_0000, "pu1_off9");

        // Write to the window: acked with 0, no effect
        set_access(1, 1'b1, RESP, 4'd1, 32'hDEAD_BEEF);
        tick();
        check("pu1_wr_ack", 64'(io_ack[1]), 64'd1);
        check("pu1_wr_data", 64'(io_ack_data[1]), 64'd0);
        rd(1, 4'd1, 32'h0000_0100, "pu1_res0_after_wr");

        // Read of a slot while it is being overwritten returns the old value
        set_result(1, 7, 16'h0999);
        set_access(1, 1'b0, RESP, 4'd8, '0);
        tick();
        check("pu1_rd_vs_wr", 64'(io_ack_data[1]), 64'h0000_0777);
        rd(1, 4'd8, 32'h0000_0999, "pu1_res7_new");

        // Unrelated address is ignored
        set_access(2, 1'b0, 8'h20, 4'd0, '0);
        tick();
        check("other_addr_no_ack", 64'(io_ack), 64'd0);

        // Reset mid-operation on PU6
        set_start(6); tick();
        set_result(6, 0, 16'h0001); tick();
        set_result(6, 1, 16'h0002); tick();
        set_access(6, 1'b0, RESP, 4'd0, '0);
        rst = 1'b1;
        tick();
        check("midrst_ack", 64'(io_ack), 64'd0);
        check("midrst_data", 64'(|io_ack_data), 64'd0);
        rst = 1'b0;
        rd(6, 4'd0, 32'h0000_0000, "pu6_after_rst");
        rd(6, 4'd1, 32'h0000_0000, "pu6_res_after_rst");
        rd(3, 4'd0, 32'h0000_0000, "pu3_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
